// File: rtl/fir_chk_pkg.sv
// Shared types and width constants for the FIR result checker.
package fir_chk_pkg;

    localparam int CHK_OUTPUT_WIDTH = 38;
    localparam int CHK_ADDR_WIDTH   = 18;
    localparam int CHK_ERR_WIDTH    = 20;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LOAD,
        WAIT_OUT,
        DONE
    } chk_state_t;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that clears on request and sticks at its all-ones value.
module sat_counter #(
    parameter int Width = 20
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [Width-1:0] count
);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (inc && (count != {Width{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/fir_result_checker.sv
// Compares each FIR result against an expected-memory word and reports a pass/fail verdict per run.
//   state    | meaning
//   IDLE     | waiting for start after reset
//   FETCH    | exp_addr presents idx to the expected memory
//   LOAD     | capture expected word, request next input sample
//   WAIT_OUT | wait for the FIR result or time out
//   DONE     | verdict held until the next start
module fir_result_checker
    import fir_chk_pkg::*;
#(
    parameter int OutputWidth   = CHK_OUTPUT_WIDTH,
    parameter int NumSamples    = 221184,
    parameter int AddrWidth     = CHK_ADDR_WIDTH,
    parameter int TimeoutCycles = 1024
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     outputValid,
    input  logic [OutputWidth-1:0]   FIR_output,
    output logic [AddrWidth-1:0]     exp_addr,
    input  logic [OutputWidth-1:0]   exp_data,
    output logic                     next_req,
    output logic                     busy,
    output logic                     done,
    output logic                     pass,
    output logic [CHK_ERR_WIDTH-1:0] err_count,
    output logic [AddrWidth-1:0]     first_err_idx,
    output logic                     first_err_valid,
    output logic                     timeout,
    output logic                     overrun
);

    localparam int WaitWidth = $clog2(TimeoutCycles + 1);

    chk_state_t             state, state_nx;
    logic [AddrWidth-1:0]   idx;
    logic [OutputWidth-1:0] exp_reg;
    logic [WaitWidth-1:0]   wait_cnt;

    logic start_ok, result_now, expired, advance, mismatch, last;

    assign start_ok   = ((state == IDLE) || (state == DONE)) && start;
    assign result_now = (state == WAIT_OUT) && outputValid;
    assign expired    = (state == WAIT_OUT) && !outputValid && (wait_cnt == '0);
    assign advance    = result_now || expired;
    assign mismatch   = (result_now && (FIR_output != exp_reg)) || expired;
    assign last       = (idx == AddrWidth'(NumSamples - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE, DONE: if (start) state_nx = FETCH;
            FETCH:      state_nx = LOAD;
            LOAD:       state_nx = WAIT_OUT;
            WAIT_OUT:   if (advance) state_nx = last ? DONE : FETCH;
            default:    state_nx = IDLE;
        endcase
    end

    always_comb begin
        next_req = (state == LOAD);
        busy     = (state != IDLE) && (state != DONE);
        done     = (state == DONE);
        pass     = done && (err_count == '0) && !timeout && !overrun;
    end

    // Timeout is a down-counter; reaching zero with no result is the terminal count.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx             <= '0;
            exp_addr        <= '0;
            exp_reg         <= '0;
            wait_cnt        <= '0;
            first_err_idx   <= '0;
            first_err_valid <= 1'b0;
            timeout         <= 1'b0;
            overrun         <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        idx             <= '0;
                        exp_addr        <= '0;
                        first_err_idx   <= '0;
                        first_err_valid <= 1'b0;
                        timeout         <= 1'b0;
                        overrun         <= 1'b0;
                    end else if (outputValid && (state == IDLE)) begin
                        overrun <= 1'b1;
                    end
                end
                FETCH: begin
                    if (outputValid) overrun <= 1'b1;
                end
                LOAD: begin
                    exp_reg  <= exp_data;
                    wait_cnt <= WaitWidth'(TimeoutCycles - 1);
                    if (outputValid) overrun <= 1'b1;
                end
                WAIT_OUT: begin
                    if (!outputValid && (wait_cnt != '0)) wait_cnt <= wait_cnt - 1'b1;
                    if (expired) timeout <= 1'b1;
                    if (mismatch && !first_err_valid) begin
                        first_err_idx   <= idx;
                        first_err_valid <= 1'b1;
                    end
                    if (advance && !last) begin
                        idx      <= idx + 1'b1;
                        exp_addr <= idx + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    sat_counter #(
        .Width(CHK_ERR_WIDTH)
    ) u_err_cnt (
        .clk  (clk),
        .rst  (rst),
        .clr  (start_ok),
        .inc  (mismatch),
        .count(err_count)
    );

endmodule

// File: doc/fir_result_checker.md
FIR_RESULT_CHECKER -- requirements
Module: fir_result_checker

Interface
REQ-001 Parameter OutputWidth, default 38, result/expected word width.
REQ-002 Parameter NumSamples, default 221184, results checked per run.
REQ-003 Parameter AddrWidth, default 18, expected-memory address width.
REQ-004 Parameter TimeoutCycles, default 1024, max wait for one result.
REQ-005 clk  input  1  single clock; all logic on rising edge.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 start  input  1  begin a run (sampled in IDLE or DONE only).
REQ-008 outputValid  input  1  FIR result strobe, one cycle per result.
REQ-009 FIR_output  input  OutputWidth  FIR result, valid with outputValid.
REQ-010 exp_addr  output  AddrWidth  expected-memory read address.
REQ-011 exp_data  input  OutputWidth  expected word, valid one cycle after exp_addr.
REQ-012 next_req  output  1  one-cycle pulse asking the stimulus side for the next input sample.
REQ-013 busy  output  1  high in any state other than IDLE and DONE.
REQ-014 done  output  1  high while in DONE.
REQ-015 pass  output  1  valid with done; high iff err_count==0 and no timeout/overrun.
REQ-016 err_count  output  20  saturating mismatch count (saturates at 2^20-1).
REQ-017 first_err_idx  output  AddrWidth  index of first mismatch; first_err_valid flags it.
REQ-018 timeout, overrun  output  1 each  sticky flags.

Function
REQ-019 FSM states: IDLE, FETCH, LOAD, WAIT_OUT, DONE.
REQ-020 IDLE/DONE + start: clear idx, err_count, first_err_*, timeout, overrun; go FETCH.
REQ-021 FETCH: drive exp_addr=idx; go LOAD next cycle.
REQ-022 LOAD: register exp_data into exp_reg; pulse next_req for exactly this cycle; clear wait counter; go WAIT_OUT.
REQ-023 WAIT_OUT + outputValid: compare FIR_output to exp_reg bitwise over full OutputWidth; mismatch increments err_count (saturating) and, if first_err_valid=0, loads first_err_idx=idx and sets first_err_valid.
REQ-024 WAIT_OUT without outputValid: increment wait counter; at TimeoutCycles set timeout, count as one mismatch (incl. first_err capture), and advance as if a result arrived.
REQ-025 Advance: if idx==NumSamples-1 go DONE, else idx+1, go FETCH; latency per sample with immediate response = 3 cycles (FETCH, LOAD, WAIT_OUT).
REQ-026 outputValid in any state other than WAIT_OUT is ignored for comparison and sets overrun.
REQ-027 DONE: done=1 held until start or rst; outputs frozen.
REQ-028 start outside IDLE/DONE is ignored.
REQ-029 exp_addr holds its value outside FETCH.

Reset
REQ-030 rst=1 at any clock, including mid-run: state=IDLE, idx=0, exp_addr=0, next_req=0, busy=0, done=0, pass=0, err_count=0, first_err_idx=0, first_err_valid=0, timeout=0, overrun=0, on the following edge.
REQ-031 rst has priority over start and outputValid in the same cycle.

Structure
REQ-032 Shared package fir_chk_pkg holds the state enum typedef and width constants (OutputWidth 38, AddrWidth 18, ErrWidth 20).
REQ-033 One sub-module sat_counter (parameterised width, clear/increment, saturating) instantiated for err_count; everything else is inline.

Verification
REQ-034 NumSamples=4, expected {5,7,9,11}, FIR returns same values 2 cycles after each next_req -> done=1, pass=1, err_count=0, four next_req pulses.
REQ-035 Same but result 2 returns 10 -> err_count=1, first_err_idx=2, first_err_valid=1, pass=0.
REQ-036 Results 1 and 3 wrong, all-ones 38-bit expected vs 0 -> err_count=2, first_err_idx=1.
REQ-037 TimeoutCycles=8, result 0 never returned -> timeout=1 after 8 wait cycles, err_count=1, run continues to DONE.
REQ-038 outputValid pulsed in FETCH -> overrun=1, err_count unchanged, pass=0 at DONE.
REQ-039 rst asserted during WAIT_OUT of sample 2 -> next cycle all outputs at reset values; fresh start completes normally.
